// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial WIDTH-bit ALU (AND, OR, ADD, SLT), one bit per clock, LSB first.
// Define SERIAL_ALU_FLAGS_EN to drive the zero/overflow flags; otherwise they are tied low.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_invert,
  input  logic             carry_in,
  input  logic [1:0]       operation,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a start strobe is accepted only on an edge where busy is low; done is a
  // single-cycle pulse and the result outputs hold their value until the next accept.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             binv_q, binv_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  logic             bit_a;
  logic             bit_b;
  logic             sum_bit;
  logic             carry_next;
  logic             slice_bit;
  logic             is_arith;
  logic             last_bit;
  logic             ovf_bit;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] final_result;

  // One-bit slice for the bit currently selected by the counter.
  always_comb begin
    bit_a      = a_q[cnt_q];
    bit_b      = b_q[cnt_q] ^ binv_q;
    sum_bit    = bit_a ^ bit_b ^ carry_q;
    carry_next = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
    is_arith   = op_q[1];
    last_bit   = (cnt_q == LAST_BIT);
    case (op_q)
      OP_AND:  slice_bit = bit_a & bit_b;
      OP_OR:   slice_bit = bit_a | bit_b;
      default: slice_bit = sum_bit;
    endcase
    shifted = {slice_bit, sh_q[WIDTH-1:1]};
    // On the MSB, carry_q is the carry into the sign bit and carry_next the carry out of it.
    ovf_bit = is_arith & (carry_q ^ carry_next);
    if (op_q == OP_SLT) begin
      final_result = {{(WIDTH-1){1'b0}}, sum_bit ^ ovf_bit};
    end else begin
      final_result = shifted;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    binv_d   = binv_q;
    op_d     = op_q;
    carry_d  = carry_q;
    sh_d     = sh_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          binv_d  = b_invert;
          op_d    = operation;
          carry_d = carry_in;
          cnt_d   = '0;
          sh_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sh_d    = shifted;
        carry_d = carry_next;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          cnt_d    = '0;
          result_d = final_result;
          cout_d   = is_arith & carry_next;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      binv_q   <= 1'b0;
      op_q     <= OP_AND;
      carry_q  <= 1'b0;
      sh_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      binv_q   <= binv_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  logic zero_q, zero_d;
  logic ovf_q, ovf_d;

  always_comb begin
    zero_d = zero_q;
    ovf_d  = ovf_q;
    if (state_q == S_RUN && last_bit) begin
      zero_d = (final_result == '0);
      ovf_d  = ovf_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero     = zero_q;
  assign overflow = ovf_q;
`else
  assign zero     = 1'b0;
  assign overflow = 1'b0;
`endif

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign carry_out   = cout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq: vector table plus start-ignore and mid-run reset sequences.
module tb_serial_alu_seq;

  localparam int W = 8;
`ifdef SERIAL_ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_invert;
  logic         carry_in;
  logic [1:0]   operation;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         overflow;
  logic [1:0]   dbg_state;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .b_invert    (b_invert),
    .carry_in    (carry_in),
    .operation   (operation),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .carry_out   (carry_out),
    .zero        (zero),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]   op;
    logic         binv;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cout;
    logic         zf;
    logic         ovf;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  int tests;
  int fails;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input vec_t v);
    @(negedge clk);
    a         = v.a;
    b         = v.b;
    operation = v.op;
    b_invert  = v.binv;
    carry_in  = v.cin;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    a         = ~v.a;
    b         = ~v.b;
    operation = ~v.op;
    b_invert  = ~v.binv;
    carry_in  = ~v.cin;
  endtask

  task automatic wait_done(output int lat, output bit seen, output bit busy_ok);
    lat = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && lat < 40) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    logic [W-1:0] exp_res;
    exp_res = exp_q.pop_front();
    check({tag, " result"}, 32'(result), 32'(exp_res));
    check({tag, " carry_out"}, 32'(carry_out), 32'(v.cout));
    check({tag, " zero"}, 32'(zero), FLAGS ? 32'(v.zf) : 32'd0);
    check({tag, " overflow"}, 32'(overflow), FLAGS ? 32'(v.ovf) : 32'd0);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic binv, input logic cin,
                              input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic [W-1:0] res, input logic cout,
                              input logic zf, input logic ovf);
    vec_t v;
    v.op = op; v.binv = binv; v.cin = cin; v.a = va; v.b = vb;
    v.res = res; v.cout = cout; v.zf = zf; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    int  lat;
    bit  seen;
    bit  busy_ok;
    int  extra_done;
    vec_t v;
    vec_t junk;

    // op encodings: 0 AND, 1 OR, 2 ADD, 3 SLT
    vecs[0]  = mk(2'd2, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    vecs[1]  = mk(2'd2, 1'b1, 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
    vecs[2]  = mk(2'd0, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(2'd1, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(2'd0, 1'b1, 1'b0, 8'hF0, 8'h3C, 8'hC0, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(2'd3, 1'b1, 1'b1, 8'hFD, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(2'd3, 1'b1, 1'b1, 8'h02, 8'hFD, 8'h00, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(2'd3, 1'b1, 1'b1, 8'h80, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1);
    vecs[8]  = mk(2'd2, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    vecs[9]  = mk(2'd2, 1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);
    vecs[10] = mk(2'd2, 1'b0, 1'b1, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(2'd1, 1'b1, 1'b0, 8'hF0, 8'h3C, 8'hF3, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(2'd0, 1'b0, 1'b0, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0);
    vecs[13] = mk(2'd3, 1'b1, 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
    vecs[14] = mk(2'd0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; operation = 2'd0; b_invert = 1'b0; carry_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset carry_out", 32'(carry_out), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(vecs[i].res);
      issue(vecs[i]);
      wait_done(lat, seen, busy_ok);
      check($sformatf("v%0d done seen", i), 32'(seen), 32'd1);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(W));
      check($sformatf("v%0d busy during run", i), 32'(busy_ok), 32'd1);
      check($sformatf("v%0d busy in done", i), 32'(busy), 32'd1);
      check_outputs($sformatf("v%0d", i), vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d done pulse width", i), 32'(done), 32'd0);
      check($sformatf("v%0d result held", i), 32'(result), 32'(vecs[i].res));
    end

    // start pulsed mid-run is ignored; only one done
    v = mk(2'd2, 1'b0, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(v.res);
    issue(v);
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'hFF; operation = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, seen, busy_ok);
    check("midrun done seen", 32'(seen), 32'd1);
    check("midrun latency", 32'(lat), 32'(W - 4));
    check_outputs("midrun", v);
    extra_done = 0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
    end
    check("midrun single done", 32'(extra_done), 32'd0);
    check("midrun idle after", 32'(busy), 32'd0);

    // start during the DONE cycle is ignored
    v = mk(2'd1, 1'b0, 1'b0, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(v.res);
    issue(v);
    wait_done(lat, seen, busy_ok);
    check("donestart done seen", 32'(seen), 32'd1);
    check_outputs("donestart", v);
    a = 8'h01; b = 8'h01; operation = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("donestart not accepted", 32'(busy), 32'd0);
    @(negedge clk);
    check("donestart still idle", 32'(busy), 32'd0);
    check("donestart result held", 32'(result), 32'h3F);

    // reset asserted while processing bit 4 discards the command
    junk = mk(2'd2, 1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    issue(junk);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset result", 32'(result), 32'd0);
    check("midreset carry_out", 32'(carry_out), 32'd0);
    check("midreset state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    check("midreset no done", 32'(extra_done), 32'd0);
    exp_q.push_back(vecs[0].res);
    issue(vecs[0]);
    wait_done(lat, seen, busy_ok);
    check("postreset done seen", 32'(seen), 32'd1);
    check("postreset latency", 32'(lat), 32'(W));
    check_outputs("postreset", vecs[0]);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
